ov7670_cfg_seq: RTL and testbench
=================================

Name: ov7670_cfg_seq

Overview:
Sequencer that walks the OV7670 register ROM and writes each {reg_addr, value} entry to the camera over SCCB (3-phase write). It drives the ROM address and consumes the ROM's registered outputs. It generates the SIO_C clock and the open-drain SIO_D line, and flags completion to the capture pipeline.

Parameters:
CLK_FREQ_HZ, 50_000_000, system clock frequency
SCCB_FREQ_HZ, 100_000, SIO_C frequency; quarter-period Q = CLK_FREQ_HZ/(4*SCCB_FREQ_HZ) cycles
REG_COUNT, 171, maximum ROM entries walked (addresses 0..REG_COUNT-1)
DEV_ADDR, 8'h42, SCCB write ID (phase 1 byte)
PWRUP_CYC, 50_000, idle cycles after start before the first transaction
SWRST_CYC, 50_000, extra wait after writing reg 0x12 with bit7 set
GAP_CYC, 400, idle cycles between transactions

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
start  in  1  one-cycle pulse; begins configuration when not busy
rom_addr  out  8  ROM entry index
rom_reg_addr  in  8  ROM register address; valid 1 clk after rom_addr changes (registered ROM)
rom_value  in  8  ROM register value; same timing as rom_reg_addr
sio_c  out  1  SCCB clock (push-pull)
sio_d_oe  out  1  1 = pull SIO_D low; 0 = release (external pull-up gives 1)
busy  out  1  high from accepted start until done
done  out  1  sticky high after the last write; cleared by the next accepted start
cfg_cnt  out  8  number of completed writes

Behaviour:
- Reset (async, immediate): sio_c=1, sio_d_oe=0, rom_addr=0, busy=0, done=0, cfg_cnt=0, state IDLE. Reset mid-transaction truncates the bus cycle without a stop condition; this is acceptable.
- States: IDLE, PWRUP, FETCH, WAIT_ROM, CHECK, START, BITS, STOP, SWRST, GAP, FINISH.
- IDLE: start=1 -> busy=1, done=0, cfg_cnt=0, rom_addr=0 -> PWRUP. start while busy is ignored.
- PWRUP: count PWRUP_CYC cycles -> FETCH.
- FETCH: rom_addr already holds the index -> WAIT_ROM (1 cycle).
- WAIT_ROM -> CHECK. In CHECK, latch {rom_reg_addr, rom_value} into a shift register.
- CHECK: if the entry is 16'hFFFF or index == REG_COUNT -> FINISH; else -> START. The FFFF check applies to the latched data.
- Quarter tick: divider counts 0..Q-1. All bus changes occur on tick boundaries only.
- START: 2 quarters with sio_c=1. Q0 sio_d_oe=0; Q1 sio_d_oe=1 (SIO_D falls while SIO_C high).
- BITS: 27 bits = 3 phases × 9 bits: DEV_ADDR, reg_addr, value, each MSB first. The 9th bit of each phase is don't-care: sio_d_oe=0, no ack check.
  - Per bit: Q0 sio_c=0 and set sio_d_oe=~bit; Q1 sio_c=0; Q2 sio_c=1; Q3 sio_c=1.
  - SIO_D changes only while SIO_C is low.
- STOP: 3 quarters. Q0 sio_c=0, sio_d_oe=1; Q1 sio_c=1, oe=1; Q2 sio_c=1, oe=0 (SIO_D rises while SIO_C high).
- After STOP: cfg_cnt++, rom_addr++ (8-bit, no wrap beyond REG_COUNT by the CHECK rule). Go to SWRST if reg_addr==8'h12 and value[7]=1, else GAP.
- SWRST: wait SWRST_CYC -> GAP. GAP: wait GAP_CYC -> FETCH.
- FINISH: busy=0, done=1, bus idle (sio_c=1, oe=0) -> IDLE. start in IDLE after done reruns from index 0.
- Transaction length: (2+27*4+3)*Q = 113*Q cycles.

Test Plan:
- Reset: assert rst mid-BITS -> same-cycle sio_c=1, sio_d_oe=0, busy=0, done=0, cfg_cnt=0, rom_addr=0.
- Single entry (CLK 4 MHz, SCCB 100 kHz, Q=10; ROM[0]={12,80}, ROM[1]=FFFF) -> sampling SIO_D on sio_c rising edges gives 0x42,x,0x12,x,0x80,x; sio_c high 20 / low 20 cycles; SWRST wait observed; done=1, cfg_cnt=1.
- Full table (171 valid entries, no marker) -> rom_addr steps 0..170, 171 transactions each 1130 cycles, cfg_cnt=171, done=1, rom_addr stops at 171.
- Start handling: start pulse while busy -> ignored, sequence unchanged; start after done -> done drops next cycle, rerun from rom_addr=0.
- Bus timing: every sio_d_oe change occurs while sio_c=0, except the START fall and the STOP rise, which occur with sio_c=1; oe=0 throughout each 9th bit.

Source files
------------

// File: rtl/ov7670_cfg_seq.sv
// ov7670_cfg_seq
// Walks the OV7670 register ROM and writes every {reg_addr, value} entry to
// the camera as an SCCB 3-phase write (ID byte, register, value; each phase is
// 8 data bits plus a don't-care 9th bit). Stops at a 16'hFFFF marker or after
// REG_COUNT entries, then raises a sticky done flag for the capture pipeline.
//
// Ports
//   clk, rst       system clock, asynchronous active-high reset
//   start          one-cycle request pulse
//   rom_addr       ROM entry index (ROM output is registered: data follows 1 clk later)
//   rom_reg_addr   ROM register address
//   rom_value      ROM register value
//   sio_c          SCCB clock, push-pull
//   sio_d_oe       1 = pull SIO_D low, 0 = release (external pull-up)
//   busy           high from accepted start until the sequence ends
//   done           sticky completion flag, cleared by the next accepted start
//   cfg_cnt        number of completed register writes
//   state_dbg      current FSM state encoding, for debug/observability
//
// Handshake: start is a request with no ready; it is taken only in a cycle
// where busy is low (IDLE or FINISH). A pulse while busy is dropped, and busy
// rising in the following cycle is the acknowledgement.
module ov7670_cfg_seq #(
  parameter int         CLK_FREQ_HZ  = 50_000_000,
  parameter int         SCCB_FREQ_HZ = 100_000,
  parameter int         REG_COUNT    = 171,
  parameter logic [7:0] DEV_ADDR     = 8'h42,
  parameter int         PWRUP_CYC    = 50_000,
  parameter int         SWRST_CYC    = 50_000,
  parameter int         GAP_CYC      = 400
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [7:0] rom_addr,
  input  logic [7:0] rom_reg_addr,
  input  logic [7:0] rom_value,
  output logic       sio_c,
  output logic       sio_d_oe,
  output logic       busy,
  output logic       done,
  output logic [7:0] cfg_cnt,
  output logic [3:0] state_dbg
);

  // Quarter period of SIO_C in system clocks.
  localparam int Q  = CLK_FREQ_HZ / (4 * SCCB_FREQ_HZ);
  localparam int QW = (Q > 1) ? $clog2(Q) : 1;

  typedef enum logic [3:0] {
    IDLE, PWRUP, FETCH, WAIT_ROM, CHECK, START, BITS, STOP, SWRST, GAP, FINISH
  } state_t;

  state_t        state, state_n;
  logic [QW-1:0] qcnt;      // position inside the current quarter
  logic [1:0]    qtr;       // quarter index inside START/bit/STOP
  logic [4:0]    bit_idx;   // 0..26 across the three 9-bit phases
  logic [31:0]   wcnt;      // cycles spent in the current wait state
  logic [15:0]   entry_q;   // latched {reg_addr, value}
  logic [26:0]   frame;
  logic          tick;
  logic          accept;
  logic          swrst_hit;

  assign tick      = (qcnt == QW'(Q - 1));
  assign accept    = start && ((state == IDLE) || (state == FINISH));
  // Writing COM7 (0x12) with bit7 set soft-resets the sensor; it needs time
  // to come back before the next write is accepted.
  assign swrst_hit = (entry_q[15:8] == 8'h12) && entry_q[7];
  // 9th bit of each phase is sent as 1, i.e. SIO_D released.
  assign frame     = {DEV_ADDR, 1'b1, entry_q[15:8], 1'b1, entry_q[7:0], 1'b1};
  assign state_dbg = state;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next state and bus outputs. Bus outputs are decoded from registered state
  // and quarter counters, so they only move on quarter boundaries.
  always_comb begin
    state_n  = state;
    sio_c    = 1'b1;
    sio_d_oe = 1'b0;
    case (state)
      IDLE:     if (start) state_n = PWRUP;
      PWRUP:    if (wcnt == 32'(PWRUP_CYC - 1)) state_n = FETCH;
      FETCH:    state_n = WAIT_ROM;
      WAIT_ROM: state_n = CHECK;
      CHECK: begin
        if ((entry_q == 16'hFFFF) || (rom_addr == 8'(REG_COUNT))) state_n = FINISH;
        else                                                      state_n = START;
      end
      START: begin
        // SIO_D falls in the second quarter while SIO_C stays high.
        sio_d_oe = (qtr == 2'd1);
        if (tick && (qtr == 2'd1)) state_n = BITS;
      end
      BITS: begin
        // Low for Q0/Q1 (data set up at Q0), high for Q2/Q3.
        sio_c    = qtr[1];
        sio_d_oe = ~frame[5'd26 - bit_idx];
        if (tick && (qtr == 2'd3) && (bit_idx == 5'd26)) state_n = STOP;
      end
      STOP: begin
        // SIO_D held low through the SIO_C rise, released while SIO_C is high.
        sio_c    = (qtr != 2'd0);
        sio_d_oe = (qtr != 2'd2);
        if (tick && (qtr == 2'd2)) state_n = swrst_hit ? SWRST : GAP;
      end
      SWRST:    if (wcnt == 32'(SWRST_CYC - 1)) state_n = GAP;
      GAP:      if (wcnt == 32'(GAP_CYC - 1)) state_n = FETCH;
      FINISH:   state_n = start ? PWRUP : IDLE;
      default:  state_n = IDLE;
    endcase
  end

  // Counters and sequencer registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      qcnt     <= '0;
      qtr      <= '0;
      wcnt     <= '0;
      bit_idx  <= '0;
      entry_q  <= '0;
      rom_addr <= '0;
      cfg_cnt  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      // Every state entry starts its timing from zero.
      if (state_n != state) begin
        qcnt <= '0;
        qtr  <= '0;
        wcnt <= '0;
      end else begin
        wcnt <= wcnt + 32'd1;
        if (tick) begin
          qcnt <= '0;
          qtr  <= qtr + 2'd1;
        end else begin
          qcnt <= qcnt + QW'(1);
        end
      end

      if (state != BITS)                  bit_idx <= '0;
      else if (tick && (qtr == 2'd3))     bit_idx <= bit_idx + 5'd1;

      // Captured on the edge into CHECK, so CHECK decides on latched data.
      // rom_addr has been stable for at least two cycles by then.
      if (state == WAIT_ROM) entry_q <= {rom_reg_addr, rom_value};

      if (accept) begin
        busy     <= 1'b1;
        done     <= 1'b0;
        cfg_cnt  <= '0;
        rom_addr <= '0;
      end

      if ((state == CHECK) && (state_n == FINISH)) begin
        busy <= 1'b0;
        done <= 1'b1;
      end

      if ((state == STOP) && (state_n != STOP)) begin
        cfg_cnt  <= cfg_cnt + 8'd1;
        rom_addr <= rom_addr + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_ov7670_cfg_seq.sv
// Bench for ov7670_cfg_seq. A bus monitor decodes SCCB start/stop conditions
// and data bits from sio_c/sio_d_oe; the main process walks the ROM contents
// as a reference to build the expected write list and timing.
module tb_ov7670_cfg_seq;

  localparam int         CLK_HZ  = 800_000;
  localparam int         SCCB_HZ = 100_000;
  localparam int         Q       = CLK_HZ / (4 * SCCB_HZ);
  localparam int         REGS    = 171;
  localparam int         PWRUP   = 50;
  localparam int         SWRST   = 70;
  localparam int         GAP     = 20;
  localparam logic [7:0] DEV     = 8'h42;

  logic       clk, rst, start;
  logic [7:0] rom_addr, rom_reg_addr, rom_value, cfg_cnt;
  logic       sio_c, sio_d_oe, busy, done;
  logic [3:0] state_dbg;

  // Registered ROM model
  logic [15:0] rom_mem [256];
  logic [15:0] rom_q;
  assign rom_reg_addr = rom_q[15:8];
  assign rom_value    = rom_q[7:0];
  always @(posedge clk) rom_q <= rom_mem[rom_addr];

  ov7670_cfg_seq #(
    .CLK_FREQ_HZ (CLK_HZ),
    .SCCB_FREQ_HZ(SCCB_HZ),
    .REG_COUNT   (REGS),
    .DEV_ADDR    (DEV),
    .PWRUP_CYC   (PWRUP),
    .SWRST_CYC   (SWRST),
    .GAP_CYC     (GAP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .rom_addr    (rom_addr),
    .rom_reg_addr(rom_reg_addr),
    .rom_value   (rom_value),
    .sio_c       (sio_c),
    .sio_d_oe    (sio_d_oe),
    .busy        (busy),
    .done        (done),
    .cfg_cnt     (cfg_cnt),
    .state_dbg   (state_dbg)
  );

  // ---------------- clock / reset / cycle counter ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------- bus monitor ----------------
  typedef struct {
    logic [26:0] bits;
    int          nb;
    int          t_start;
    int          t_stop;
    int          addr;
    int          bad_h;
    int          bad_l;
    int          bad_oe;
  } txn_t;

  txn_t got_q[$];
  int   stray = 0;   // SIO_D edges outside any transaction

  initial begin : mon
    logic        pc, po, in_txn, seen_fall;
    logic [27:0] sh;
    int          nb, last_edge, pend_low;
    txn_t        cur;
    pc = 1'b1; po = 1'b0; in_txn = 1'b0; seen_fall = 1'b0;
    sh = '0; nb = 0; last_edge = 0; pend_low = -1;
    cur = '{default: 0};
    forever begin
      @(negedge clk);
      if (rst) begin
        in_txn = 1'b0;   // truncated transaction is discarded
        pc = sio_c;
        po = sio_d_oe;
      end else begin
        if (!in_txn) begin
          if (pc && sio_c && !po && sio_d_oe) begin
            in_txn = 1'b1;
            cur = '{default: 0};
            cur.t_start = cyc;
            cur.addr = int'(rom_addr);
            sh = '0; nb = 0; last_edge = cyc; seen_fall = 1'b0; pend_low = -1;
          end else if (po != sio_d_oe) begin
            stray++;
          end
        end else begin
          if (!pc && sio_c) begin
            if (pend_low >= 0 && pend_low != 2 * Q) cur.bad_l = cur.bad_l + 1;
            pend_low = cyc - last_edge;
            last_edge = cyc;
            sh = {sh[26:0], ~sio_d_oe};
            nb++;
          end else if (pc && !sio_c) begin
            if (seen_fall && (cyc - last_edge) != 2 * Q) cur.bad_h = cur.bad_h + 1;
            seen_fall = 1'b1;
            last_edge = cyc;
          end
          if ((po != sio_d_oe) && sio_c) begin
            if (pc && po && !sio_d_oe) begin
              // Stop: the final SIO_C rise belongs to the stop, not to data.
              if (pend_low != Q) cur.bad_l = cur.bad_l + 1;
              cur.t_stop = cyc;
              cur.bits = sh[27:1];
              cur.nb = nb - 1;
              got_q.push_back(cur);
              in_txn = 1'b0;
            end else begin
              cur.bad_oe = cur.bad_oe + 1;
            end
          end
        end
        pc = sio_c;
        po = sio_d_oe;
      end
    end
  end

  // ---------------- scoreboard ----------------
  int          total = 0;
  int          bad   = 0;
  logic [15:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic pulse_start(output int t);
    @(posedge clk);
    #1 start = 1'b1;
    t = cyc;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  function automatic logic [15:0] rnd_entry();
    return 16'($urandom_range(0, 65534));
  endfunction

  // ---------------- stimulus ----------------
  typedef struct {
    int n;          // entries before the marker (or table length)
    bit marker;     // place 16'hFFFF at index n
    int mode;       // 0 random, 1 soft-reset entry first, 2 COM7 with/without bit7
    bit poke;       // extra start pulse while busy
    int exp_cnt;
    int exp_addr;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int   t_pulse, t_dummy, x, budget, waited, prev_ref, exp_gap, n_got;
    txn_t g;
    logic [15:0] e;

    vecs[0] = '{n: 1,   marker: 1'b1, mode: 1, poke: 1'b0, exp_cnt: 1,   exp_addr: 1};
    vecs[1] = '{n: 3,   marker: 1'b1, mode: 0, poke: 1'b1, exp_cnt: 3,   exp_addr: 3};
    vecs[2] = '{n: 0,   marker: 1'b1, mode: 0, poke: 1'b0, exp_cnt: 0,   exp_addr: 0};
    vecs[3] = '{n: 4,   marker: 1'b1, mode: 2, poke: 1'b0, exp_cnt: 4,   exp_addr: 4};
    vecs[4] = '{n: 171, marker: 1'b0, mode: 0, poke: 1'b0, exp_cnt: 171, exp_addr: 171};

    rst = 1'b1;
    start = 1'b0;
    for (int a = 0; a < 256; a++) rom_mem[a] = 16'h0101;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sio_c", sio_c, 1);
    chk("rst_oe", sio_d_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cfg_cnt", cfg_cnt, 0);
    chk("rst_rom_addr", rom_addr, 0);
    rst = 1'b0;

    // Reset in the middle of the second transaction's first data bit.
    rom_mem[0] = 16'h2011;
    rom_mem[1] = 16'h2122;
    rom_mem[2] = 16'hFFFF;
    pulse_start(t_pulse);
    x = t_pulse + (PWRUP + 4 + Q) + 111 * Q + (2 * Q + GAP + 3) + Q + 1;
    budget = 0;
    do begin
      @(posedge clk);
      #1;
      budget++;
    end while (cyc < x && budget < 2000);
    #1;
    chk("pre_rst_sio_c", sio_c, 0);
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_cfg_cnt", cfg_cnt, 1);
    chk("pre_rst_rom_addr", rom_addr, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_sio_c", sio_c, 1);
    chk("mid_rst_oe", sio_d_oe, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_cfg_cnt", cfg_cnt, 0);
    chk("mid_rst_rom_addr", rom_addr, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 5; i++) begin
      for (int a = 0; a < 256; a++) rom_mem[a] = rnd_entry();
      if (vecs[i].mode == 1) rom_mem[0] = 16'h1280;
      if (vecs[i].mode == 2) begin
        rom_mem[1] = 16'h127F;
        rom_mem[2] = 16'h12C5;
      end
      if (vecs[i].marker) rom_mem[vecs[i].n] = 16'hFFFF;

      // Reference: walk the ROM until the marker or the table length.
      exp_q.delete();
      for (int k = 0; k < REGS && rom_mem[k] != 16'hFFFF; k++) exp_q.push_back(rom_mem[k]);
      got_q.delete();

      if (i > 0) chk("done_sticky", done, 1);
      pulse_start(t_pulse);
      chk("start_busy", busy, 1);
      chk("start_done_clr", done, 0);
      chk("start_cfg_cnt", cfg_cnt, 0);
      chk("start_rom_addr", rom_addr, 0);

      if (vecs[i].poke) begin
        repeat (300) @(posedge clk);
        #1;
        pulse_start(t_dummy);
        chk("poke_busy", busy, 1);
      end

      budget = PWRUP + 400 + (vecs[i].n + 1) * (113 * Q + 2 * Q + GAP + 3 + SWRST);
      waited = 0;
      while (done !== 1'b1 && waited < budget) begin
        @(posedge clk);
        #1;
        waited++;
      end
      chk("done_seen", done, 1);
      chk("end_busy", busy, 0);
      chk("end_cfg_cnt", cfg_cnt, vecs[i].exp_cnt);
      chk("end_rom_addr", rom_addr, vecs[i].exp_addr);
      chk("end_sio_c", sio_c, 1);
      chk("end_oe", sio_d_oe, 0);

      n_got = got_q.size();
      chk("txn_count", n_got, exp_q.size());
      prev_ref = t_pulse;
      exp_gap = PWRUP + 4 + Q;
      for (int k = 0; k < exp_q.size() && got_q.size() > 0; k++) begin
        g = got_q.pop_front();
        e = exp_q[k];
        chk("txn_addr", g.addr, k);
        chk("txn_frame", g.bits, {DEV, 1'b1, e[15:8], 1'b1, e[7:0], 1'b1});
        chk("txn_nbits", g.nb, 27);
        chk("txn_len", g.t_stop - g.t_start, 111 * Q);
        chk("txn_high", g.bad_h, 0);
        chk("txn_low", g.bad_l, 0);
        chk("txn_oe_edge", g.bad_oe, 0);
        chk("txn_gap", g.t_start - prev_ref, exp_gap);
        prev_ref = g.t_stop;
        exp_gap = 2 * Q + GAP + 3 + (((e[15:8] == 8'h12) && e[7]) ? SWRST : 0);
      end
    end

    chk("stray_oe", stray, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
